// File: rtl/game_sequencer.sv
// Match-level controller for the counter game: sequences clear/load/play/over
// and arbitrates the two players' access to the counter control field.
module game_sequencer #(
  parameter int SIZE      = 4,
  parameter int CTRL_HOLD = 4,
  parameter int OVER_HOLD = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            auto_restart,
  input  logic [SIZE-1:0] seed,
  input  logic            seed_valid,
  input  logic [1:0]      req,
  input  logic [1:0]      ctrl_p0,
  input  logic [1:0]      ctrl_p1,
  input  logic            GAMEOVER,
  input  logic [1:0]      WHO,
  output logic [1:0]      gnt,
  output logic            INIT_c,
  output logic [SIZE-1:0] INIT_l,
  output logic [1:0]      control,
  output logic            game_reset,
  output logic            busy,
  output logic [7:0]      games_done,
  output logic [1:0]      last_who
);

  localparam int HW = $clog2(CTRL_HOLD + 1);
  localparam int OW = $clog2(OVER_HOLD + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, PLAY, OVER} state_t;

  state_t          state, state_d;
  logic [HW-1:0]   hold_cnt, hold_cnt_d;
  logic [OW-1:0]   over_cnt, over_cnt_d;
  logic            rr_last, rr_last_d;
  logic [1:0]      gnt_d;
  logic            init_c_d;
  logic [SIZE-1:0] init_l_d;
  logic [1:0]      control_d;
  logic            game_reset_d;
  logic            busy_d;
  logic [7:0]      games_done_d;
  logic [1:0]      last_who_d;

  // rr_last=1 means player1 was granted last, so player0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      over_cnt   <= '0;
      rr_last    <= 1'b1;
      gnt        <= 2'b00;
      INIT_c     <= 1'b0;
      INIT_l     <= '0;
      control    <= 2'b00;
      game_reset <= 1'b1;
      busy       <= 1'b0;
      games_done <= 8'd0;
      last_who   <= 2'b00;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_cnt_d;
      over_cnt   <= over_cnt_d;
      rr_last    <= rr_last_d;
      gnt        <= gnt_d;
      INIT_c     <= init_c_d;
      INIT_l     <= init_l_d;
      control    <= control_d;
      game_reset <= game_reset_d;
      busy       <= busy_d;
      games_done <= games_done_d;
      last_who   <= last_who_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = LOAD;
      LOAD:    state_d = PLAY;
      PLAY:    if (GAMEOVER) state_d = OVER;
      OVER:    if (over_cnt == '0) state_d = auto_restart ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_cnt_d   = hold_cnt;
    over_cnt_d   = over_cnt;
    rr_last_d    = rr_last;
    gnt_d        = 2'b00;
    control_d    = control;
    games_done_d = games_done;
    last_who_d   = last_who;
    init_l_d     = INIT_l;
    init_c_d     = (state_d == LOAD);
    busy_d       = (state_d != IDLE);
    game_reset_d = !((state_d == LOAD) || (state_d == PLAY));

    if (state_d == CLEAR && state != CLEAR)
      init_l_d = seed_valid ? seed : '0;

    if (state == OVER && over_cnt != '0)
      over_cnt_d = over_cnt - 1'b1;

    if (state == PLAY) begin
      if (GAMEOVER) begin
        hold_cnt_d   = '0;
        over_cnt_d   = OW'(OVER_HOLD - 1);
        last_who_d   = WHO;
        games_done_d = (games_done == 8'hFF) ? 8'hFF : games_done + 8'd1;
      end else if (hold_cnt > HW'(1)) begin
        // locked window: req and ctrl changes are ignored until the last cycle
        hold_cnt_d = hold_cnt - 1'b1;
        gnt_d      = gnt;
      end else begin
        hold_cnt_d = HW'(CTRL_HOLD);
        case (req)
          2'b01: begin
            gnt_d     = 2'b01;
            control_d = ctrl_p0;
          end
          2'b10: begin
            gnt_d     = 2'b10;
            control_d = ctrl_p1;
          end
          2'b11: begin
            if (rr_last) begin
              gnt_d     = 2'b01;
              control_d = ctrl_p0;
              rr_last_d = 1'b0;
            end else begin
              gnt_d     = 2'b10;
              control_d = ctrl_p1;
              rr_last_d = 1'b1;
            end
          end
          default: hold_cnt_d = '0;
        endcase
      end
    end else begin
      hold_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with default parameters.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       auto_restart;
  logic [3:0] seed;
  logic       seed_valid;
  logic [1:0] req;
  logic [1:0] ctrl_p0;
  logic [1:0] ctrl_p1;
  logic       GAMEOVER;
  logic [1:0] WHO;
  logic [1:0] gnt;
  logic       INIT_c;
  logic [3:0] INIT_l;
  logic [1:0] control;
  logic       game_reset;
  logic       busy;
  logic [7:0] games_done;
  logic [1:0] last_who;

  int checks = 0;
  int failures = 0;

  game_sequencer #(.SIZE(4), .CTRL_HOLD(4), .OVER_HOLD(2)) dut (
    .clk(clk), .reset(reset), .start(start), .auto_restart(auto_restart),
    .seed(seed), .seed_valid(seed_valid), .req(req), .ctrl_p0(ctrl_p0),
    .ctrl_p1(ctrl_p1), .GAMEOVER(GAMEOVER), .WHO(WHO), .gnt(gnt),
    .INIT_c(INIT_c), .INIT_l(INIT_l), .control(control),
    .game_reset(game_reset), .busy(busy), .games_done(games_done),
    .last_who(last_who)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; auto_restart = 1'b0; seed = 4'h0; seed_valid = 1'b0;
    req = 2'b00; ctrl_p0 = 2'b00; ctrl_p1 = 2'b00; GAMEOVER = 1'b0; WHO = 2'b00;
    #12;
    checks++;
    if ({gnt, INIT_c, INIT_l, control, game_reset, busy, games_done, last_who} !==
        {2'b00, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 8'd0, 2'b00}) begin
      failures++;
      $display("[TB] FAIL reset_values: gnt=%b INIT_c=%b INIT_l=%h control=%b game_reset=%b busy=%b games_done=%0d last_who=%b expected 00 0 0 00 1 0 0 00",
               gnt, INIT_c, INIT_l, control, game_reset, busy, games_done, last_who);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || game_reset !== 1'b1) begin
      failures++;
      $display("[TB] FAIL idle_hold: busy=%b game_reset=%b expected 0 1", busy, game_reset);
    end
  endtask

  task automatic test_start();
    seed = 4'h9; seed_valid = 1'b1; start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || game_reset !== 1'b1 || INIT_l !== 4'h9 || INIT_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clear_state: busy=%b game_reset=%b INIT_l=%h INIT_c=%b expected 1 1 9 0",
               busy, game_reset, INIT_l, INIT_c);
    end
    start = 1'b0;
    tick();
    checks++;
    if (INIT_c !== 1'b1 || game_reset !== 1'b0 || INIT_l !== 4'h9) begin
      failures++;
      $display("[TB] FAIL load_state: INIT_c=%b game_reset=%b INIT_l=%h expected 1 0 9",
               INIT_c, game_reset, INIT_l);
    end
    tick();
    checks++;
    if (INIT_c !== 1'b0 || busy !== 1'b1 || game_reset !== 1'b0 || gnt !== 2'b00) begin
      failures++;
      $display("[TB] FAIL play_entry: INIT_c=%b busy=%b game_reset=%b gnt=%b expected 0 1 0 00",
               INIT_c, busy, game_reset, gnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [1:0] exp_ctrl;
    req = 2'b11; ctrl_p0 = 2'b10; ctrl_p1 = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 1) ctrl_p0 = 2'b01;
      exp_gnt  = (i < 4 || i >= 8) ? 2'b01 : 2'b10;
      exp_ctrl = (i < 4) ? 2'b10 : (i < 8) ? 2'b11 : 2'b01;
      checks++;
      if (gnt !== exp_gnt || control !== exp_ctrl) begin
        failures++;
        $display("[TB] FAIL round_robin[%0d]: gnt=%b control=%b expected %b %b",
                 i, gnt, control, exp_gnt, exp_ctrl);
      end
    end
    req = 2'b00;
    tick();
    checks++;
    if (gnt !== 2'b00 || control !== 2'b01) begin
      failures++;
      $display("[TB] FAIL rr_release: gnt=%b control=%b expected 00 01", gnt, control);
    end
  endtask

  task automatic test_ctrl_hold();
    req = 2'b01; ctrl_p0 = 2'b01;
    tick();
    ctrl_p0 = 2'b11;
    req = 2'b10;
    checks++;
    if (gnt !== 2'b01 || control !== 2'b01) begin
      failures++;
      $display("[TB] FAIL hold_grant: gnt=%b control=%b expected 01 01", gnt, control);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      if (i == 3) req = 2'b00;
      checks++;
      if (gnt !== 2'b01 || control !== 2'b01) begin
        failures++;
        $display("[TB] FAIL hold_locked[%0d]: gnt=%b control=%b expected 01 01", i, gnt, control);
      end
    end
    tick();
    checks++;
    if (gnt !== 2'b00 || control !== 2'b01) begin
      failures++;
      $display("[TB] FAIL hold_release: gnt=%b control=%b expected 00 01", gnt, control);
    end
  endtask

  task automatic test_gameover();
    req = 2'b10; ctrl_p1 = 2'b10; GAMEOVER = 1'b1; WHO = 2'b10; auto_restart = 1'b0;
    tick();
    checks++;
    if (gnt !== 2'b00 || control !== 2'b01 || game_reset !== 1'b1 || last_who !== 2'b10 ||
        games_done !== 8'd1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL gameover_entry: gnt=%b control=%b game_reset=%b last_who=%b games_done=%0d busy=%b expected 00 01 1 10 1 1",
               gnt, control, game_reset, last_who, games_done, busy);
    end
    WHO = 2'b01;
    tick();
    GAMEOVER = 1'b0;
    checks++;
    if (game_reset !== 1'b1 || games_done !== 8'd1 || last_who !== 2'b10 || busy !== 1'b1 || gnt !== 2'b00) begin
      failures++;
      $display("[TB] FAIL over_hold: game_reset=%b games_done=%0d last_who=%b busy=%b gnt=%b expected 1 1 10 1 00",
               game_reset, games_done, last_who, busy, gnt);
    end
    tick();
    req = 2'b00;
    checks++;
    if (busy !== 1'b0 || game_reset !== 1'b1 || games_done !== 8'd1 || INIT_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL over_to_idle: busy=%b game_reset=%b games_done=%0d INIT_c=%b expected 0 1 1 0",
               busy, game_reset, games_done, INIT_c);
    end
  endtask

  task automatic test_auto_restart();
    int exp_done;
    seed_valid = 1'b0; auto_restart = 1'b1; start = 1'b1; WHO = 2'b00;
    tick();
    start = 1'b0;
    checks++;
    if (INIT_l !== 4'h0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL zero_seed_load: INIT_l=%h busy=%b expected 0 1", INIT_l, busy);
    end
    tick();
    tick();
    for (int g = 0; g < 258; g++) begin
      GAMEOVER = 1'b1;
      tick();
      GAMEOVER = 1'b0;
      exp_done = (g + 2 > 255) ? 255 : g + 2;
      checks++;
      if (games_done !== exp_done[7:0] || last_who !== 2'b00) begin
        failures++;
        $display("[TB] FAIL games_done[%0d]: games_done=%0d last_who=%b expected %0d 00",
                 g, games_done, last_who, exp_done);
      end
      tick();
      tick();
      if (g == 0) begin
        checks++;
        if (INIT_l !== 4'h0 || busy !== 1'b1 || game_reset !== 1'b1 || INIT_c !== 1'b0) begin
          failures++;
          $display("[TB] FAIL auto_restart_clear: INIT_l=%h busy=%b game_reset=%b INIT_c=%b expected 0 1 1 0",
                   INIT_l, busy, game_reset, INIT_c);
        end
      end
      tick();
      if (g == 0) begin
        checks++;
        if (INIT_c !== 1'b1) begin
          failures++;
          $display("[TB] FAIL auto_restart_load: INIT_c=%b expected 1", INIT_c);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_play();
    auto_restart = 1'b0; req = 2'b01; ctrl_p0 = 2'b10;
    tick();
    start = 1'b1;
    checks++;
    if (gnt !== 2'b01 || control !== 2'b10) begin
      failures++;
      $display("[TB] FAIL midplay_grant: gnt=%b control=%b expected 01 10", gnt, control);
    end
    tick();
    checks++;
    if (gnt !== 2'b01 || game_reset !== 1'b0 || busy !== 1'b1 || INIT_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL start_ignored: gnt=%b game_reset=%b busy=%b INIT_c=%b expected 01 0 1 0",
               gnt, game_reset, busy, INIT_c);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({gnt, INIT_c, INIT_l, control, game_reset, busy, games_done, last_who} !==
        {2'b00, 1'b0, 4'h0, 2'b00, 1'b1, 1'b0, 8'd0, 2'b00}) begin
      failures++;
      $display("[TB] FAIL async_reset: gnt=%b INIT_c=%b INIT_l=%h control=%b game_reset=%b busy=%b games_done=%0d last_who=%b expected 00 0 0 00 1 0 0 00",
               gnt, INIT_c, INIT_l, control, game_reset, busy, games_done, last_who);
    end
    start = 1'b0;
    req = 2'b00;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_start();
    test_round_robin();
    test_ctrl_hold();
    test_gameover();
    test_auto_restart();
    test_reset_mid_play();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
